// File: rtl/axi_route_pkg.sv
// Shared AXI write-routing types, default queue depth and the slave address map.
// Latency: n/a (types and constants). Backpressure: n/a.
package axi_route_pkg;

    localparam int RT_ADDR_W = 32;
    localparam int RT_LEN_W  = 8;
    localparam int RT_DEPTH  = 4;

    typedef struct packed {
        logic [RT_ADDR_W-1:0] addr;
        logic [RT_LEN_W-1:0]  len;
    } route_entry_t;

    // Slave windows are [base, limit): base inclusive, limit exclusive.
    localparam logic [31:0] SLV0_BASE  = 32'h0000_0000;
    localparam logic [31:0] SLV0_LIMIT = 32'h0000_8000;
    localparam logic [31:0] SLV1_BASE  = 32'h0008_0000;
    localparam logic [31:0] SLV1_LIMIT = 32'h0008_0200;
    localparam logic [31:0] SLV2_BASE  = 32'h0010_0000;
    localparam logic [31:0] SLV2_LIMIT = 32'h0010_8000;
    localparam logic [31:0] SLV3_BASE  = 32'h1A10_0000;
    localparam logic [31:0] SLV3_LIMIT = 32'h1A12_0000;
    localparam logic [31:0] SLV4_BASE  = 32'h0002_0000;
    localparam logic [31:0] SLV4_LIMIT = 32'h0002_1000;
    localparam logic [2:0]  SLV_DEFAULT = 3'd5;

    function automatic logic [2:0] addr_to_slave(input logic [31:0] a);
        logic [2:0] sel;
        sel = SLV_DEFAULT;
        if      (a >= SLV0_BASE && a < SLV0_LIMIT) sel = 3'd0;
        else if (a >= SLV1_BASE && a < SLV1_LIMIT) sel = 3'd1;
        else if (a >= SLV2_BASE && a < SLV2_LIMIT) sel = 3'd2;
        else if (a >= SLV3_BASE && a < SLV3_LIMIT) sel = 3'd3;
        else if (a >= SLV4_BASE && a < SLV4_LIMIT) sel = 3'd4;
        return sel;
    endfunction

endpackage

// File: rtl/route_fifo.sv
// Generic synchronous FIFO with registered pointers; head/count/full/empty derive from them.
// Latency: a push is visible at head the cycle after. Backpressure: push ignored when full, pop ignored when empty.
module route_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Extra pointer MSB tells a full ring (MSBs differ) from an empty one (MSBs equal).
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/w_route_sequencer.sv
// Queues AW {addr,len} in order and steers each W burst to its slave via Address_decode.
// Latency: route usable the cycle after aw_fire. Backpressure: AW stalls when full, W stalls when empty or x_WREADY low.
module w_route_sequencer
    import axi_route_pkg::*;
#(
    parameter int ADDR_W = RT_ADDR_W,
    parameter int LEN_W  = RT_LEN_W,
    parameter int DEPTH  = RT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        m_AWADDR,
    input  logic [LEN_W-1:0]         m_AWLEN,
    input  logic                     m_AWVALID,
    output logic                     m_AWREADY,
    output logic                     s_AWVALID,
    input  logic                     s_AWREADY,
    input  logic                     m_WVALID,
    input  logic                     m_WLAST,
    output logic                     m_WREADY,
    output logic                     x_WVALID,
    input  logic                     x_WREADY,
    output logic [ADDR_W-1:0]        Address_decode,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     wlast_err
);
    localparam int EW = ADDR_W + LEN_W;

    logic [EW-1:0]     head;
    logic [ADDR_W-1:0] head_addr;
    logic [LEN_W-1:0]  head_len;
    logic [LEN_W-1:0]  beat_cnt;
    logic              full;
    logic              empty;
    logic              aw_fire;
    logic              w_fire;
    logic              last_beat;
    logic              burst_end;

    assign head_addr = head[EW-1:LEN_W];
    assign head_len  = head[LEN_W-1:0];

    // Full/empty come from registered pointers only, so no AWREADY<-WREADY or AWVALID->W path exists.
    assign m_AWREADY = ~rst & s_AWREADY & ~full;
    assign s_AWVALID = ~rst & m_AWVALID & ~full;
    assign m_WREADY  = ~rst & x_WREADY & ~empty;
    assign x_WVALID  = ~rst & m_WVALID & ~empty;
    assign Address_decode = empty ? '0 : head_addr;

    assign aw_fire   = m_AWVALID & m_AWREADY;
    assign w_fire    = x_WVALID & x_WREADY;
    assign last_beat = (beat_cnt == head_len);
    assign burst_end = w_fire & last_beat;

    route_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_route_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (aw_fire),
        .din   ({m_AWADDR, m_AWLEN}),
        .pop   (burst_end),
        .head  (head),
        .count (outstanding),
        .full  (full),
        .empty (empty)
    );

    // Burst end is length-based; WLAST is only cross-checked, never used to pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            wlast_err <= 1'b0;
        end else begin
            wlast_err <= w_fire & (m_WLAST != last_beat);
            if (burst_end)   beat_cnt <= '0;
            else if (w_fire) beat_cnt <= beat_cnt + 1'b1;
        end
    end

endmodule
